// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes,
// opcode classes and the datapath mux-select values.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_IMM, C_LW, C_SW, C_BR, C_J, C_JAL, C_JR, C_ILL
    } op_class_t;

    localparam logic [5:0] OP_R      = 6'd0;
    localparam logic [5:0] OP_IMM_LO = 6'd1;
    localparam logic [5:0] OP_IMM_HI = 6'd15;
    localparam logic [5:0] OP_LW     = 6'd16;
    localparam logic [5:0] OP_SW     = 6'd24;
    localparam logic [5:0] OP_BEQ    = 6'd32;
    localparam logic [5:0] OP_BNE    = 6'd33;
    localparam logic [5:0] OP_BLT    = 6'd34;
    localparam logic [5:0] OP_BLE    = 6'd35;
    localparam logic [5:0] OP_J      = 6'd40;
    localparam logic [5:0] OP_JAL    = 6'd41;
    localparam logic [5:0] OP_JR     = 6'd42;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    localparam logic [1:0] WS_RD     = 2'd0;
    localparam logic [1:0] WS_RT     = 2'd1;
    localparam logic [1:0] WS_R31    = 2'd2;

    localparam logic [1:0] WD_ALU    = 2'd0;
    localparam logic [1:0] WD_MEM    = 2'd1;
    localparam logic [1:0] WD_PC4    = 2'd2;

endpackage

// File: rtl/op_class_decode.sv
// Maps a 6-bit opcode onto its instruction class; anything unlisted is illegal.
module op_class_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    output op_class_t  cls,
    output logic       illegal
);

    // opcode -> class lookup
    always_comb begin
        cls = C_ILL;
        if (op == OP_R)
            cls = C_R;
        else if (op >= OP_IMM_LO && op <= OP_IMM_HI)
            cls = C_IMM;
        else begin
            case (op)
                OP_LW:                          cls = C_LW;
                OP_SW:                          cls = C_SW;
                OP_BEQ, OP_BNE, OP_BLT, OP_BLE: cls = C_BR;
                OP_J:                           cls = C_J;
                OP_JAL:                         cls = C_JAL;
                OP_JR:                          cls = C_JR;
                default:                        cls = C_ILL;
            endcase
        end
        illegal = (cls == C_ILL);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the MIPS-style datapath. One shared variable-latency
// memory port serves fetch and load/store through req/ack handshakes.
// Optional build macro PERF_CNT_EN adds cycle / retire counters; without it
// cyc_cnt and ret_cnt are tied to 0 and no counter flops exist.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstd,
    input  logic             run,
    input  logic [5:0]       op,
    input  logic             br_taken,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wsel,
    output logic [1:0]       wdata_sel,
    output logic             alu_src,
    output logic             halted,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    state_t     st;
    logic [5:0] op_q;
    logic       ill_q;
    logic [5:0] dec_op;
    op_class_t  cls;
    logic       cls_ill;

    logic       ireq, dreq, dwe, irwe, pcwe, rfwe, asrc;
    logic [1:0] psel, ws, wd;

    // DECODE classifies the live opcode; later states use the latched copy
    assign dec_op = (st == S_DECODE) ? op : op_q;

    op_class_decode u_dec (
        .op      (dec_op),
        .cls     (cls),
        .illegal (cls_ill)
    );

    // per-state datapath enables; pc_we marks the retire cycle
    always_comb begin
        ireq = 1'b0; dreq = 1'b0; dwe  = 1'b0; irwe = 1'b0;
        pcwe = 1'b0; rfwe = 1'b0; asrc = 1'b0;
        psel = PC_PLUS4; ws = WS_RD; wd = WD_ALU;
        case (st)
            S_FETCH: begin
                ireq = 1'b1;
                irwe = imem_ack;
            end
            S_EXEC: begin
                asrc = cls inside {C_IMM, C_LW, C_SW};
                case (cls)
                    C_BR:  begin pcwe = 1'b1; psel = br_taken ? PC_BRANCH : PC_PLUS4; end
                    C_J:   begin pcwe = 1'b1; psel = PC_JUMP; end
                    C_JAL: begin
                        pcwe = 1'b1; psel = PC_JUMP;
                        rfwe = 1'b1; ws = WS_R31; wd = WD_PC4;
                    end
                    C_JR:  begin pcwe = 1'b1; psel = PC_REG; end
                    default: ;
                endcase
            end
            S_MEM: begin
                dreq = 1'b1;
                dwe  = (cls == C_SW);
                pcwe = (cls == C_SW) && dmem_ack;
            end
            S_WB: begin
                rfwe = 1'b1;
                pcwe = 1'b1;
                ws   = (cls == C_R)  ? WS_RD  : WS_RT;
                wd   = (cls == C_LW) ? WD_MEM : WD_ALU;
            end
            default: ;
        endcase
    end

    // state sequencing; run only matters in IDLE and on the retire cycle
    always_ff @(posedge clk) begin
        if (rstd) begin
            st    <= S_IDLE;
            op_q  <= '0;
            ill_q <= 1'b0;
        end else begin
            case (st)
                S_IDLE:   if (run) st <= S_FETCH;
                S_FETCH:  if (imem_ack) st <= S_DECODE;
                S_DECODE: begin
                    op_q <= op;
                    if (cls_ill) begin
                        st    <= S_HALT;
                        ill_q <= 1'b1;
                    end else begin
                        st <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (pcwe)
                        st <= run ? S_FETCH : S_IDLE;
                    else if (cls == C_LW || cls == C_SW)
                        st <= S_MEM;
                    else
                        st <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (cls == C_LW) st <= S_WB;
                        else             st <= run ? S_FETCH : S_IDLE;
                    end
                end
                S_WB:     st <= run ? S_FETCH : S_IDLE;
                S_HALT:   st <= S_HALT;
                default:  st <= S_IDLE;
            endcase
        end
    end

    // reset forces every output low at once, dropping any open request
    assign imem_req  = !rstd && ireq;
    assign dmem_req  = !rstd && dreq;
    assign dmem_we   = !rstd && dwe;
    assign ir_we     = !rstd && irwe;
    assign pc_we     = !rstd && pcwe;
    assign rf_we     = !rstd && rfwe;
    assign alu_src   = !rstd && asrc;
    assign pc_sel    = rstd ? 2'd0 : psel;
    assign wsel      = rstd ? 2'd0 : ws;
    assign wdata_sel = rstd ? 2'd0 : wd;
    assign halted    = !rstd && (st == S_HALT);
    assign illegal   = !rstd && ill_q;
    assign state     = rstd ? 3'd0 : st;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, ret_q;

    // busy-cycle and retirement counters, wrapping naturally
    always_ff @(posedge clk) begin
        if (rstd) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (st inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB})
                cyc_q <= cyc_q + CNT_W'(1);
            if (pcwe)
                ret_q <= ret_q + CNT_W'(1);
        end
    end

    assign cyc_cnt = rstd ? '0 : cyc_q;
    assign ret_cnt = rstd ? '0 : ret_q;
`else
    assign cyc_cnt = '0;
    assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction table, reset/halt corner
// sequences, and random instruction streams checked against a per-instruction
// trace model.
module tb_multicycle_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rstd, run, br_taken, imem_ack, dmem_ack;
    logic [5:0]       op;
    logic             imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
    logic             alu_src, halted, illegal;
    logic [1:0]       pc_sel, wsel, wdata_sel;
    logic [2:0]       state;
    logic [CNT_W-1:0] cyc_cnt, ret_cnt;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rstd(rstd), .run(run), .op(op), .br_taken(br_taken),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .rf_we(rf_we), .wsel(wsel), .wdata_sel(wdata_sel),
        .alu_src(alu_src), .halted(halted), .illegal(illegal), .state(state),
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ireq, dreq, dwe, irwe, pcwe;
        logic [1:0] psel;
        logic       rfwe;
        logic [1:0] ws, wd;
        logic       asrc, hlt, ill;
        logic [2:0] st;
    } exp_t;

    typedef struct {
        logic       run, iack, dack, br;
        logic [5:0] op;
        exp_t       e;
    } cyc_t;

    typedef struct {
        int         op;
        bit         br;
        int         iw, dw, cyc;
        logic [1:0] ps;
        logic       rf;
        logic [1:0] ws, wd;
    } vec_t;

    exp_t             act;
    cyc_t             q[$];
    vec_t             tbl[12];
    int               total = 0, bad = 0;
    logic [CNT_W-1:0] m_cyc, m_ret;
    int               legal_ops[13] = '{0, 1, 7, 15, 16, 24, 32, 33, 34, 35, 40, 41, 42};

    assign act = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we,
                  wsel, wdata_sel, alu_src, halted, illegal, state};

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    function automatic logic [CNT_W-1:0] perf(input logic [CNT_W-1:0] v);
`ifdef PERF_CNT_EN
        return v;
`else
        return '0;
`endif
    endfunction

    // a cycle record with random don't-care inputs and all outputs idle
    function automatic cyc_t blank(input logic [2:0] s);
        cyc_t c;
        c.run  = 1'($urandom);
        c.iack = 1'($urandom);
        c.dack = 1'($urandom);
        c.br   = 1'($urandom);
        c.op   = 6'($urandom);
        c.e    = '0;
        c.e.st = s;
        return c;
    endfunction

    // reference trace of one instruction, built from the class rules
    task automatic gen(input int opv, input bit brv, input int iw, input int dw,
                       input bit run_end, input bit from_idle);
        cyc_t c;
        bit is_r, is_imm, is_lw, is_sw, is_br, is_j, is_jal, is_jr, ctl, legal;
        is_r   = (opv == 0);
        is_imm = (opv >= 1 && opv <= 15);
        is_lw  = (opv == 16);
        is_sw  = (opv == 24);
        is_br  = (opv >= 32 && opv <= 35);
        is_j   = (opv == 40);
        is_jal = (opv == 41);
        is_jr  = (opv == 42);
        ctl    = is_br | is_j | is_jal | is_jr;
        legal  = is_r | is_imm | is_lw | is_sw | ctl;
        if (from_idle) begin
            repeat ($urandom_range(0, 2)) begin
                c = blank(3'd0); c.run = 1'b0; q.push_back(c);
            end
            c = blank(3'd0); c.run = 1'b1; q.push_back(c);
        end
        for (int i = 0; i <= iw; i++) begin
            c = blank(3'd1);
            c.iack = (i == iw);
            c.e.ireq = 1'b1;
            c.e.irwe = (i == iw);
            q.push_back(c);
        end
        c = blank(3'd2); c.op = 6'(opv); q.push_back(c);
        if (!legal) begin
            repeat (20) begin
                c = blank(3'd6); c.run = 1'b1; c.e.hlt = 1'b1; c.e.ill = 1'b1;
                q.push_back(c);
            end
            return;
        end
        c = blank(3'd3);
        c.br = brv;
        c.e.asrc = is_imm | is_lw | is_sw;
        if (ctl) begin
            c.run = run_end;
            c.e.pcwe = 1'b1;
            c.e.psel = is_br ? (brv ? 2'd1 : 2'd0) : (is_jr ? 2'd3 : 2'd2);
            if (is_jal) begin c.e.rfwe = 1'b1; c.e.ws = 2'd2; c.e.wd = 2'd2; end
        end
        q.push_back(c);
        if (is_lw | is_sw) begin
            for (int i = 0; i <= dw; i++) begin
                c = blank(3'd4);
                c.dack = (i == dw);
                c.e.dreq = 1'b1;
                c.e.dwe = is_sw;
                if (is_sw && i == dw) begin c.e.pcwe = 1'b1; c.run = run_end; end
                q.push_back(c);
            end
        end
        if (is_r | is_imm | is_lw) begin
            c = blank(3'd5);
            c.run = run_end;
            c.e.rfwe = 1'b1;
            c.e.pcwe = 1'b1;
            c.e.ws = is_r ? 2'd0 : 2'd1;
            c.e.wd = is_lw ? 2'd1 : 2'd0;
            q.push_back(c);
        end
    endtask

    // play queued records one per cycle, checking outputs and counters
    task automatic apply_q(input string tag);
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk); #1;
            run = c.run; imem_ack = c.iack; dmem_ack = c.dack;
            br_taken = c.br; op = c.op;
            @(negedge clk);
            chk({tag, "/outputs"}, 64'(act), 64'(c.e));
            chk({tag, "/cyc_cnt"}, 64'(cyc_cnt), 64'(perf(m_cyc)));
            chk({tag, "/ret_cnt"}, 64'(ret_cnt), 64'(perf(m_ret)));
            if (c.e.st >= 3'd1 && c.e.st <= 3'd5) m_cyc = m_cyc + 1'b1;
            if (c.e.pcwe) m_ret = m_ret + 1'b1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstd = 1'b1; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
        @(negedge clk);
        chk("reset/outputs", 64'(act), 64'd0);
        chk("reset/cyc_cnt", 64'(cyc_cnt), 64'd0);
        chk("reset/ret_cnt", 64'(ret_cnt), 64'd0);
        @(posedge clk); #1;
        rstd = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        m_cyc = '0; m_ret = '0;
        @(negedge clk);
        chk("reset/idle", 64'(act), 64'd0);
    endtask

    // one directed instruction; the bench answers requests after iw/dw waits
    task automatic run_vec(input vec_t v, input int idx);
        int n = 0, ic = 0, dc = 0;
        bit done = 1'b0;
        run = 1'b1; op = 6'(v.op); br_taken = v.br;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            imem_ack = imem_req && (ic == v.iw);
            dmem_ack = dmem_req && (dc == v.dw);
            if (imem_req) ic++;
            if (dmem_req) dc++;
            @(negedge clk);
            n++;
            if (pc_we) begin
                done = 1'b1;
                chk($sformatf("vec%0d/cycles", idx), 64'(n), 64'(v.cyc));
                chk($sformatf("vec%0d/pc_sel", idx), 64'(pc_sel), 64'(v.ps));
                chk($sformatf("vec%0d/rf_we", idx), 64'(rf_we), 64'(v.rf));
                chk($sformatf("vec%0d/wsel", idx), 64'(wsel), 64'(v.ws));
                chk($sformatf("vec%0d/wdata_sel", idx), 64'(wdata_sel), 64'(v.wd));
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL vec%0d/timeout: no retire within 40 cycles", idx);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit re;
        rstd = 1'b1; run = 1'b0; op = '0; br_taken = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; m_cyc = '0; m_ret = '0;
        //           op br iw dw cyc ps rf ws wd
        tbl[0]  = '{ 0, 0, 0, 0, 4, 2'd0, 1'b1, 2'd0, 2'd0};
        tbl[1]  = '{ 5, 0, 1, 0, 5, 2'd0, 1'b1, 2'd1, 2'd0};
        tbl[2]  = '{16, 0, 0, 2, 7, 2'd0, 1'b1, 2'd1, 2'd1};
        tbl[3]  = '{24, 0, 0, 0, 4, 2'd0, 1'b0, 2'd0, 2'd0};
        tbl[4]  = '{24, 0, 1, 1, 6, 2'd0, 1'b0, 2'd0, 2'd0};
        tbl[5]  = '{32, 1, 0, 0, 3, 2'd1, 1'b0, 2'd0, 2'd0};
        tbl[6]  = '{33, 0, 0, 0, 3, 2'd0, 1'b0, 2'd0, 2'd0};
        tbl[7]  = '{40, 0, 0, 0, 3, 2'd2, 1'b0, 2'd0, 2'd0};
        tbl[8]  = '{41, 0, 0, 0, 3, 2'd2, 1'b1, 2'd2, 2'd2};
        tbl[9]  = '{42, 0, 0, 0, 3, 2'd3, 1'b0, 2'd0, 2'd0};
        tbl[10] = '{35, 1, 2, 0, 5, 2'd1, 1'b0, 2'd0, 2'd0};
        tbl[11] = '{15, 0, 0, 0, 4, 2'd0, 1'b1, 2'd1, 2'd0};

        do_reset();
        foreach (tbl[i]) run_vec(tbl[i], i);

        // random instruction stream with waits, ack noise and run drops
        do_reset();
        re = 1'b0;
        for (int k = 0; k < 60; k++) begin
            int  opv;
            bit  from_idle;
            from_idle = !re || (k == 0);
            opv = legal_ops[$urandom_range(0, 12)];
            re  = ($urandom_range(0, 9) < 7);
            gen(opv, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), re, from_idle);
            apply_q("rand");
        end

        // undefined opcode halts for good, run notwithstanding
        do_reset();
        gen(63, 1'b0, 1, 0, 1'b1, 1'b1);
        apply_q("halt");
        do_reset();

        // reset lands while a store waits in MEM
        gen(24, 1'b0, 0, 10, 1'b1, 1'b1);
        repeat (9) void'(q.pop_back());
        apply_q("rst_mem");
        @(posedge clk); #1;
        rstd = 1'b1; run = 1'b1; dmem_ack = 1'b0;
        @(negedge clk);
        chk("rst_mem/dmem_req", 64'(dmem_req), 64'd0);
        chk("rst_mem/outputs", 64'(act), 64'd0);
        @(posedge clk); #1;
        rstd = 1'b0; run = 1'b0;
        @(negedge clk);
        chk("rst_mem/state", 64'(state), 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            run = 1'b0; imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
            @(negedge clk);
            chk("idle_hold/outputs", 64'(act), 64'd0);
            chk("idle_hold/cyc_cnt", 64'(cyc_cnt), 64'd0);
            chk("idle_hold/ret_cnt", 64'(ret_cnt), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
